micro_ucr_hash_multi: RTL and testbench
=======================================

# micro_ucr_hash_multi

Parametrised parallel nonce-search engine, successor to the fixed 4-instance hash top. NUM_LANES lanes run the existing `generar_W` and `algo_hash` datapath, one per lane. The lanes share one data block and search interleaved nonce sequences through a registered two-stage pipeline. A control FSM stops the search on the first hit, resolves simultaneous hits by lane priority, and reports the nonce, hash and lane index. It also supports a round limit and reports nonce-space exhaustion.

## Interface
- `NUM_LANES`, default 4: parallel lanes. Must be a power of two, 1..16.
- `LANE_W`, default `$clog2(NUM_LANES)` with a minimum of 1: lane index width. Local parameter, not overridable.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `inicio`, input, 1: reset, synchronous and active-high. While high, all state clears and the inputs are captured. The first edge sampled with it low starts the search.
- `bloque_datos`, input, 96: data block, shared by all lanes.
- `nonce_base`, input, 32: first nonce of lane 0.
- `target`, input, 8: difficulty threshold.
- `max_rondas`, input, 32: round limit; 0 means unlimited.
- `terminado_out`, output, 1: a hit was found; held high.
- `agotado_out`, output, 1: the search ended without a hit; held high.
- `ocupado_out`, output, 1: search in progress.
- `bounty_out`, output, 24: hash H of the winning nonce.
- `nonce_out`, output, 32: winning nonce.
- `lane_out`, output, LANE_W: lane that produced the winner.

## Operation
- FSM states: IDLE, BUSCAR, FIN, AGOTADO. `inicio`=1 forces IDLE from any state, mid-search included.
- In IDLE:
  - `bloque_datos`, `nonce_base`, `target` and `max_rondas` are registered every cycle.
  - Lane i nonce register loads `nonce_base + i`.
  - The issued-round counter, the pipeline-valid bit and all outputs clear to 0.
- Input capture: inputs are sampled only while `inicio`=1. Changes while `inicio`=0 are ignored.
- Stage 1 (per lane): the lane i nonce register feeds the combinational hash of `{bloque_datos, nonce}` (128-bit block).
  - Hit condition: `H[23:16] < target` AND `H[15:8] < target`, both unsigned.
- Stage 2 (per lane): registers the hit flag, H and the nonce. A shared valid bit marks that the stage-2 contents belong to an issued round.
- BUSCAR, each edge while issuing, i.e. while the issued-round count is below the limit:
  - Each nonce register advances by NUM_LANES, modulo 2^32.
  - The issued-round counter (33-bit) increments.
  - Stage 2 captures and valid is set.
- Effective limit = `max_rondas` if non-zero, otherwise 2^32/NUM_LANES (the full nonce space, every nonce tried exactly once). If `max_rondas` exceeds 2^32/NUM_LANES, the space limit applies.
- Once the limit is reached, no further rounds issue. On the next edge the final round's stage-2 contents are checked and valid then clears.
- Arbiter: on each edge in BUSCAR with valid=1, if any stage-2 hit is set, the lowest-index hitting lane wins. Its H, nonce and index are registered to the outputs, `terminado_out` goes to 1 and the FSM moves to FIN. Later hits, in the same round or already in flight, are discarded.
- If the final round is checked without a hit, the FSM moves to AGOTADO and `agotado_out` goes to 1. Outputs `bounty_out`, `nonce_out` and `lane_out` stay 0.
- FIN and AGOTADO hold all outputs and stop all counters until `inicio`=1.
- `ocupado_out` = 1 exactly in BUSCAR. `terminado_out` and `agotado_out` are never high together.

## Timing
- Reset values (IDLE): every output is 0.
- Edge E0 is the first rising edge with `inicio`=0. At E0 the FSM enters BUSCAR, stage 2 captures round 0 and round 1 is issued.
- Earliest hit: checked at E1, so `terminado_out` is visible after E1, i.e. two edges after `inicio` falls.
- A hit in round r is reported after edge E(r+1).
- With limit L and no hit, `agotado_out` is visible after edge E(L).
- One round = NUM_LANES nonces per cycle. Throughput is NUM_LANES hashes per clock.
- Asserting `inicio` during BUSCAR: the next edge clears everything. A hit pending in stage 2 is dropped, not reported.

## Test plan
- NUM_LANES=4, target=8'h00 (hit impossible), max_rondas=5 -> `ocupado_out` high for edges E0..E4; `agotado_out`=1 after E5; `bounty_out`, `nonce_out`, `lane_out` = 0.
- NUM_LANES=4, nonce_base=32'h0000_0010, target chosen so the golden single-lane model's first hit is nonce 32'h0000_0016 -> `nonce_out`=32'h16, `lane_out`=2, `terminado_out` after E2, `bounty_out` equal to the model's H.
- Simultaneous hit: a data block where nonces base+1 and base+3 both hit in round 0 -> `lane_out`=1, `nonce_out`=base+1, after E1.
- Wrap-around: NUM_LANES=4, nonce_base=32'hFFFF_FFFE, target=0, max_rondas=2 -> round 1 lane 3 uses nonce 32'h0000_0005; `agotado_out` after E2; no X on any output.
- Reset mid-operation: `inicio` raised at E3 of a search whose hit would report at E4 -> all outputs 0 after the next edge. Restarting with a new nonce_base repeats the timing from E0.
- NUM_LANES=1 and NUM_LANES=16 regressions against the golden model over 200 random blocks. The first hit nonce equals the model's lowest hitting nonce ≥ nonce_base.

Source files
------------

// File: rtl/micro_ucr_hash_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | micro_ucr_hash_multi : NUM_LANES-wide nonce search over the micro-UCR hash |
// | Also holds generar_W (message expansion) and algo_hash (compression).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module generar_W (
    input  logic [127:0] bloque,
    output logic [255:0] w
);
    function automatic logic [255:0] expandir(input logic [127:0] b);
        logic [7:0]   v [32];
        logic [255:0] res;
        for (int i = 0; i < 16; i++) v[i] = b[127-8*i -: 8];
        for (int i = 16; i < 32; i++) v[i] = v[i-3] | (v[i-9] ^ v[i-14]);
        for (int i = 0; i < 32; i++) res[255-8*i -: 8] = v[i];
        return res;
    endfunction

    assign w = expandir(bloque);
endmodule

module algo_hash (
    input  logic [255:0] w,
    output logic [23:0]  h
);
    function automatic logic [23:0] comprimir(input logic [255:0] wv);
        logic [7:0] a, b, c, x, k, c_prev;
        a = 8'h01;
        b = 8'h89;
        c = 8'hFE;
        for (int i = 0; i < 32; i++) begin
            x      = (i <= 16) ? (a ^ b) : (a | b);
            k      = (i <= 16) ? 8'h99 : 8'hA1;
            c_prev = c;
            a      = b ^ c_prev;
            b      = {c_prev[3:0], c_prev[7:4]};
            c      = x + k + wv[255-8*i -: 8];
        end
        return {a, b, c};
    endfunction

    assign h = comprimir(w);
endmodule

module micro_ucr_hash_multi #(
    parameter  int NUM_LANES = 4,
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic              clk,
    input  logic              inicio,
    input  logic [95:0]       bloque_datos,
    input  logic [31:0]       nonce_base,
    input  logic [7:0]        target,
    input  logic [31:0]       max_rondas,
    output logic              terminado_out,
    output logic              agotado_out,
    output logic              ocupado_out,
    output logic [23:0]       bounty_out,
    output logic [31:0]       nonce_out,
    output logic [LANE_W-1:0] lane_out
);
    localparam int          c_desplaz        = $clog2(NUM_LANES);
    localparam logic [32:0] c_rondas_espacio = 33'h1_0000_0000 >> c_desplaz;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSCAR  = 2'd1,
        FIN     = 2'd2,
        AGOTADO = 2'd3
    } estado_t;

    estado_t r_estado, w_estado_sig;

    logic [95:0]                  r_bloque;
    logic [7:0]                   r_target;
    logic [32:0]                  r_limite;
    logic [32:0]                  r_rondas;
    logic [31:0]                  r_nonce    [NUM_LANES];
    logic                         r_valido;
    logic [NUM_LANES-1:0]         r_s2_hit;
    logic [23:0]                  r_s2_h     [NUM_LANES];
    logic [31:0]                  r_s2_nonce [NUM_LANES];

    logic                         r_terminado, r_agotado;
    logic [23:0]                  r_bounty;
    logic [31:0]                  r_nonce_out;
    logic [LANE_W-1:0]            r_lane;

    logic [NUM_LANES-1:0][23:0]   w_h;
    logic [NUM_LANES-1:0]         w_hit;
    logic [32:0]                  w_limite_in;
    logic                         w_emitiendo, w_hay_hit, w_avanza, w_toma_hit, w_agota;
    logic [LANE_W-1:0]            w_ganador;
    logic [23:0]                  w_ganador_h;
    logic [31:0]                  w_ganador_nonce;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [255:0] w_w;
        generar_W u_generar_w (.bloque({r_bloque, r_nonce[g]}), .w(w_w));
        algo_hash u_algo_hash (.w(w_w), .h(w_h[g]));
        assign w_hit[g] = (w_h[g][23:16] < r_target) && (w_h[g][15:8] < r_target);
    end

    // A zero or oversized round limit falls back to one full pass over the nonce space.
    assign w_limite_in = ((max_rondas == 32'd0) || ({1'b0, max_rondas} > c_rondas_espacio))
                         ? c_rondas_espacio : {1'b0, max_rondas};

    assign w_emitiendo = (r_rondas < r_limite);
    assign w_hay_hit   = r_valido && (|r_s2_hit);

    always_comb begin
        w_ganador       = '0;
        w_ganador_h     = '0;
        w_ganador_nonce = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (r_s2_hit[i]) begin
                w_ganador       = LANE_W'(i);
                w_ganador_h     = r_s2_h[i];
                w_ganador_nonce = r_s2_nonce[i];
            end
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        w_toma_hit   = 1'b0;
        w_agota      = 1'b0;
        w_avanza     = 1'b0;
        case (r_estado)
            IDLE: begin
                w_estado_sig = BUSCAR;
                w_avanza     = w_emitiendo;
            end
            BUSCAR: begin
                if (w_hay_hit) begin
                    w_estado_sig = FIN;
                    w_toma_hit   = 1'b1;
                end else if (!w_emitiendo) begin
                    w_estado_sig = AGOTADO;
                    w_agota      = 1'b1;
                end else begin
                    w_avanza     = 1'b1;
                end
            end
            default: w_estado_sig = r_estado;
        endcase
    end

    always_ff @(posedge clk) begin
        if (inicio) r_estado <= IDLE;
        else        r_estado <= w_estado_sig;
    end

    always_ff @(posedge clk) begin
        if (inicio) begin
            r_bloque    <= bloque_datos;
            r_target    <= target;
            r_limite    <= w_limite_in;
            r_rondas    <= '0;
            r_valido    <= 1'b0;
            r_s2_hit    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_nonce[i]    <= nonce_base + 32'(i);
                r_s2_h[i]     <= '0;
                r_s2_nonce[i] <= '0;
            end
            r_terminado <= 1'b0;
            r_agotado   <= 1'b0;
            r_bounty    <= '0;
            r_nonce_out <= '0;
            r_lane      <= '0;
        end else begin
            r_valido <= w_avanza;
            if (w_avanza) begin
                r_rondas <= r_rondas + 33'd1;
                r_s2_hit <= w_hit;
                for (int i = 0; i < NUM_LANES; i++) begin
                    r_nonce[i]    <= r_nonce[i] + 32'(NUM_LANES);
                    r_s2_h[i]     <= w_h[i];
                    r_s2_nonce[i] <= r_nonce[i];
                end
            end
            if (w_toma_hit) begin
                r_terminado <= 1'b1;
                r_bounty    <= w_ganador_h;
                r_nonce_out <= w_ganador_nonce;
                r_lane      <= w_ganador;
            end
            if (w_agota) r_agotado <= 1'b1;
        end
    end

    assign terminado_out = r_terminado;
    assign agotado_out   = r_agotado;
    assign ocupado_out   = (r_estado == BUSCAR);
    assign bounty_out    = r_bounty;
    assign nonce_out     = r_nonce_out;
    assign lane_out      = r_lane;

endmodule
`default_nettype wire

// File: tb/tb_micro_ucr_hash_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_micro_ucr_hash_multi : scoreboard bench for lane counts 4, 1 and 16     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_micro_ucr_hash_multi;

    typedef struct {
        bit          hit;
        logic [31:0] nonce;
        logic [23:0] h;
        int          lane;
        int          edge_idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        inicio = 1'b1;
    logic [95:0] bloque = '0;
    logic [31:0] base = '0;
    logic [7:0]  tgt = '0;
    logic [31:0] maxr = '0;

    logic [2:0]  fin_v, ago_v, ocu_v;
    logic [23:0] bnt_v [3];
    logic [31:0] non_v [3];
    logic [3:0]  lan_v [3];
    logic [1:0]  l4;
    logic [0:0]  l1;
    logic [3:0]  l16;

    int n_checks = 0;
    int n_errors = 0;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    micro_ucr_hash_multi #(.NUM_LANES(4)) u_dut4 (
        .clk(clk), .inicio(inicio), .bloque_datos(bloque), .nonce_base(base),
        .target(tgt), .max_rondas(maxr), .terminado_out(fin_v[0]), .agotado_out(ago_v[0]),
        .ocupado_out(ocu_v[0]), .bounty_out(bnt_v[0]), .nonce_out(non_v[0]), .lane_out(l4));
    micro_ucr_hash_multi #(.NUM_LANES(1)) u_dut1 (
        .clk(clk), .inicio(inicio), .bloque_datos(bloque), .nonce_base(base),
        .target(tgt), .max_rondas(maxr), .terminado_out(fin_v[1]), .agotado_out(ago_v[1]),
        .ocupado_out(ocu_v[1]), .bounty_out(bnt_v[1]), .nonce_out(non_v[1]), .lane_out(l1));
    micro_ucr_hash_multi #(.NUM_LANES(16)) u_dut16 (
        .clk(clk), .inicio(inicio), .bloque_datos(bloque), .nonce_base(base),
        .target(tgt), .max_rondas(maxr), .terminado_out(fin_v[2]), .agotado_out(ago_v[2]),
        .ocupado_out(ocu_v[2]), .bounty_out(bnt_v[2]), .nonce_out(non_v[2]), .lane_out(l16));

    assign lan_v[0] = {2'b00, l4};
    assign lan_v[1] = {3'b000, l1};
    assign lan_v[2] = l16;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nl(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    // Golden single-lane hash: expansion then 32 compression rounds.
    function automatic logic [23:0] hash_ref(input logic [127:0] blk);
        logic [7:0] w [32];
        logic [7:0] a, b, c, x, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[127-8*i -: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        a = 8'h01; b = 8'h89; c = 8'hFE;
        for (int i = 0; i < 32; i++) begin
            x = (i <= 16) ? (a ^ b) : (a | b);
            k = (i <= 16) ? 8'h99 : 8'hA1;
            t = c;
            a = b ^ t;
            b = {t[3:0], t[7:4]};
            c = x + k + w[i];
        end
        return {a, b, c};
    endfunction

    function automatic int mval(input logic [95:0] blk, input logic [31:0] nonce);
        logic [23:0] h;
        h = hash_ref({blk, nonce});
        return (h[23:16] > h[15:8]) ? int'(h[23:16]) : int'(h[15:8]);
    endfunction

    function automatic int minm(input logic [95:0] blk, input logic [31:0] b, input int lo, input int hi);
        int m = 256;
        for (int o = lo; o <= hi; o++) begin
            int v = mval(blk, b + 32'(o));
            if (v < m) m = v;
        end
        return m;
    endfunction

    function automatic exp_t modelo(input int n, input logic [95:0] blk, input logic [31:0] b,
                                    input logic [7:0] t, input logic [31:0] mx);
        exp_t   e;
        longint space, lim;
        bit     found = 0;
        space = 64'h1_0000_0000 / n;
        lim   = (mx == 0 || longint'(mx) > space) ? space : longint'(mx);
        e.hit = 0; e.nonce = '0; e.h = '0; e.lane = 0; e.edge_idx = int'(lim);
        for (longint k = 0; k < lim * n && !found; k++) begin
            logic [31:0] nc;
            logic [23:0] h;
            nc = b + 32'(k);
            h  = hash_ref({blk, nc});
            if (h[23:16] < t && h[15:8] < t) begin
                found = 1;
                e.hit = 1; e.nonce = nc; e.h = h;
                e.lane = int'(k % n); e.edge_idx = int'(k / n) + 1;
            end
        end
        return e;
    endfunction

    task automatic push(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int d, output exp_t e);
        case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic apply_reset(input logic [95:0] blk, input logic [31:0] b,
                               input logic [7:0] t, input logic [31:0] mx);
        @(negedge clk);
        inicio = 1'b1; bloque = blk; base = b; tgt = t; maxr = mx;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_test(input string nm, input logic [95:0] blk, input logic [31:0] b,
                            input logic [7:0] t, input logic [31:0] mx);
        exp_t       e;
        logic [2:0] done, ocu_bad;
        apply_reset(blk, b, t, mx);
        for (int d = 0; d < 3; d++) begin
            push(d, modelo(nl(d), blk, b, t, mx));
            chk($sformatf("%s d%0d reset", nm, d),
                {fin_v[d], ago_v[d], ocu_v[d], bnt_v[d], non_v[d], lan_v[d]}, 64'd0);
        end
        // Inputs change after the search starts; the captured copy must be used.
        inicio = 1'b0; bloque = ~blk; base = ~b; tgt = ~t; maxr = 32'd1;
        done = '0; ocu_bad = '0;
        for (int ed = 0; ed < 200 && done != 3'b111; ed++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (!done[d]) begin
                    if (fin_v[d] || ago_v[d]) begin
                        pop(d, e);
                        done[d] = 1'b1;
                        chk($sformatf("%s d%0d flags", nm, d), {fin_v[d], ago_v[d]}, {e.hit, !e.hit});
                        chk($sformatf("%s d%0d nonce", nm, d), non_v[d], e.nonce);
                        chk($sformatf("%s d%0d bounty", nm, d), bnt_v[d], e.h);
                        chk($sformatf("%s d%0d lane", nm, d), lan_v[d], e.lane);
                        chk($sformatf("%s d%0d edge", nm, d), ed, e.edge_idx);
                        chk($sformatf("%s d%0d busy_end", nm, d), ocu_v[d], 0);
                    end else if (ocu_v[d] !== 1'b1) begin
                        ocu_bad[d] = 1'b1;
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            if (!done[d]) pop(d, e);
            chk($sformatf("%s d%0d timeout", nm, d), done[d], 1);
            chk($sformatf("%s d%0d busy", nm, d), ocu_bad[d], 0);
        end
    endtask

    // Finds a block whose lowest hitting offset in [0,hi_b] lies in [lo_b,hi_b].
    task automatic find_block(input logic [31:0] b, input int hi_a, input int lo_b, input int hi_b,
                              output logic [95:0] blk, output logic [7:0] t, output bit ok);
        ok = 0; blk = '0; t = '0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            logic [95:0] cand;
            int          ma;
            cand = {$urandom, $urandom, $urandom};
            ma   = minm(cand, b, 0, hi_a);
            if (minm(cand, b, lo_b, hi_b) < ma) begin
                ok = 1; blk = cand; t = 8'(ma);
            end
        end
    endtask

    initial begin
        logic [95:0] blk;
        logic [31:0] b;
        logic [7:0]  t;
        bit          ok;

        run_test("exhaust", {$urandom, $urandom, $urandom}, 32'h0000_0100, 8'h00, 32'd5);

        find_block(32'h0000_0010, 5, 6, 6, blk, t, ok);
        chk("search16", ok, 1);
        run_test("first16", blk, 32'h0000_0010, t, 32'd0);

        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            int m0;
            blk = {$urandom, $urandom, $urandom};
            b   = $urandom;
            m0  = mval(blk, b);
            if (mval(blk, b + 32'd1) < m0 && mval(blk, b + 32'd3) < m0) begin
                ok = 1; t = 8'(m0);
            end
        end
        chk("search_simul", ok, 1);
        run_test("simul", blk, b, t, 32'd0);

        run_test("wrap_nohit", {$urandom, $urandom, $urandom}, 32'hFFFF_FFFE, 8'h00, 32'd2);
        find_block(32'hFFFF_FFFE, 6, 7, 7, blk, t, ok);
        chk("search_wrap", ok, 1);
        run_test("wrap_hit", blk, 32'hFFFF_FFFE, t, 32'd2);

        // Abort a search whose lane-count-4 hit would report after E4.
        b = 32'h0000_4000;
        find_block(b, 11, 12, 15, blk, t, ok);
        chk("search_abort", ok, 1);
        apply_reset(blk, b, t, 32'd0);
        inicio = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort pre busy", {fin_v[0], ocu_v[0]}, 2'b01);
        @(negedge clk);
        inicio = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("abort d%0d cleared", d),
                {fin_v[d], ago_v[d], ocu_v[d], bnt_v[d], non_v[d], lan_v[d]}, 64'd0);
        @(posedge clk); #1;
        chk("abort dropped", {fin_v[0], non_v[0]}, 33'd0);
        run_test("restart", blk, b + 32'd8, t, 32'd6);

        for (int i = 0; i < 200; i++)
            run_test($sformatf("rnd%0d", i), {$urandom, $urandom, $urandom}, $urandom,
                     8'($urandom_range(1, 48)), 32'($urandom_range(1, 40)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
